// File: rtl/cve2_pkg.sv
// Shared types for the RVFI trace buffer: record layout, control states and flag bit positions.
package cve2_pkg;

  localparam int unsigned FLAG_TRAP = 0;
  localparam int unsigned FLAG_INTR = 1;
  localparam int unsigned FLAG_LOST = 2;
  localparam int unsigned FLAGS_W   = 3;

  typedef struct packed {
    logic [31:0]        order;
    logic [31:0]        pc;
    logic [31:0]        insn;
    logic [4:0]         rd_addr;
    logic [31:0]        rd_wdata;
    logic [FLAGS_W-1:0] flags;
  } trace_rec_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FROZEN
  } trace_buf_state_e;

endpackage

// File: rtl/cve2_trace_fifo.sv
// Generic registered circular FIFO; the head is presented from storage, so a push becomes
// visible on the following cycle. Flush beats push and pop in the same cycle.
module cve2_trace_fifo #(
  parameter int unsigned Depth  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        data_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic              wr_en;

  assign wr_en = push_i & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_i, pop_i})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; the head is masked while empty so outputs read zero after reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = (level_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o = level_q;

endmodule

// File: rtl/cve2_rvfi_trace_buffer.sv
// RVFI retirement trace buffer: run/stop FSM, drop accounting and a drained record FIFO.
// Optional freeze-on-trap behaviour is enabled by defining CVE2_TRACE_BUF_FREEZE_ON_TRAP_EN.
module cve2_rvfi_trace_buffer
  import cve2_pkg::*;
#(
  parameter int unsigned Depth        = 16,
  parameter int unsigned DropCntWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     trace_en_i,
  input  logic                     clear_i,
  input  logic                     rvfi_valid,
  input  logic [63:0]              rvfi_order,
  input  logic [31:0]              rvfi_insn,
  input  logic                     rvfi_trap,
  input  logic                     rvfi_intr,
  input  logic [31:0]              rvfi_pc_rdata,
  input  logic [4:0]               rvfi_rd_addr,
  input  logic [31:0]              rvfi_rd_wdata,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [31:0]              trace_order_o,
  output logic [31:0]              trace_pc_o,
  output logic [31:0]              trace_insn_o,
  output logic [4:0]               trace_rd_addr_o,
  output logic [31:0]              trace_rd_wdata_o,
  output logic [2:0]               trace_flags_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic [DropCntWidth-1:0]  drop_cnt_o,
  output logic                     frozen_o
);

  localparam int unsigned LvlW = $clog2(Depth) + 1;

  trace_buf_state_e        state_q, state_d;
  logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;
  logic                    lost_pending_q, lost_pending_d;
  logic                    pop, push, drop, capture, has_slot;
  trace_rec_t              push_rec, head_rec;
  logic                    unused_order_hi;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop      = trace_valid_o & trace_ready_i;
  assign has_slot = (level_o != LvlW'(Depth)) | pop;
  assign capture  = (state_q == RUN) & rvfi_valid & ~clear_i;
  assign push     = capture & has_slot;
  assign drop     = capture & ~has_slot;

  assign unused_order_hi = ^rvfi_order[63:32];

  always_comb begin
    push_rec                 = '0;
    push_rec.order           = rvfi_order[31:0];
    push_rec.pc              = rvfi_pc_rdata;
    push_rec.insn            = rvfi_insn;
    push_rec.rd_addr         = rvfi_rd_addr;
    push_rec.rd_wdata        = rvfi_rd_wdata;
    push_rec.flags[FLAG_TRAP] = rvfi_trap;
    push_rec.flags[FLAG_INTR] = rvfi_intr;
    push_rec.flags[FLAG_LOST] = lost_pending_q;
  end

  always_comb begin
    state_d        = state_q;
    drop_cnt_d     = drop_cnt_q;
    lost_pending_d = lost_pending_q;
    if (clear_i) begin
      state_d        = IDLE;
      drop_cnt_d     = '0;
      lost_pending_d = 1'b0;
    end else begin
      if (push) lost_pending_d = 1'b0;
      if (drop) begin
        lost_pending_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DropCntWidth'(1);
      end
      unique case (state_q)
        IDLE: if (trace_en_i) state_d = RUN;
        RUN: begin
          if (!trace_en_i) state_d = IDLE;
`ifdef CVE2_TRACE_BUF_FREEZE_ON_TRAP_EN
          // A trap freezes capture whether its record was stored or dropped.
          if (rvfi_valid && rvfi_trap) state_d = FROZEN;
`endif
        end
        FROZEN:  state_d = FROZEN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      drop_cnt_q     <= '0;
      lost_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      drop_cnt_q     <= drop_cnt_d;
      lost_pending_q <= lost_pending_d;
    end
  end

  cve2_trace_fifo #(
    .Depth  (Depth),
    .DATA_W ($bits(trace_rec_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (push),
    .data_i  (push_rec),
    .pop_i   (pop),
    .valid_o (trace_valid_o),
    .data_o  (head_rec),
    .level_o (level_o)
  );

  assign trace_order_o    = head_rec.order;
  assign trace_pc_o       = head_rec.pc;
  assign trace_insn_o     = head_rec.insn;
  assign trace_rd_addr_o  = head_rec.rd_addr;
  assign trace_rd_wdata_o = head_rec.rd_wdata;
  assign trace_flags_o    = head_rec.flags;
  assign drop_cnt_o       = drop_cnt_q;

`ifdef CVE2_TRACE_BUF_FREEZE_ON_TRAP_EN
  assign frozen_o = (state_q == FROZEN);
`else
  assign frozen_o = 1'b0;
`endif

endmodule

// File: tb/tb_cve2_rvfi_trace_buffer.sv
// Self-checking bench for cve2_rvfi_trace_buffer: directed table, corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_cve2_rvfi_trace_buffer;

  localparam int DEPTH = 16;
  localparam int DW    = 4;
  localparam int DMAX  = (1 << DW) - 1;
`ifdef CVE2_TRACE_BUF_FREEZE_ON_TRAP_EN
  localparam bit FREEZE = 1'b1;
`else
  localparam bit FREEZE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, clear = 1'b0, valid = 1'b0, trap = 1'b0, intr = 1'b0, ready = 1'b0;
  logic [63:0] order = '0;
  logic [31:0] insn = '0, pc = '0, wdata = '0;
  logic [4:0]  rd = '0;
  logic        t_valid, frozen;
  logic [31:0] t_order, t_pc, t_insn, t_wdata;
  logic [4:0]  t_rd, level;
  logic [2:0]  t_flags;
  logic [DW-1:0] drops;

  always #5 clk = ~clk;

  cve2_rvfi_trace_buffer #(.Depth(DEPTH), .DropCntWidth(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .trace_en_i(en), .clear_i(clear),
    .rvfi_valid(valid), .rvfi_order(order), .rvfi_insn(insn), .rvfi_trap(trap),
    .rvfi_intr(intr), .rvfi_pc_rdata(pc), .rvfi_rd_addr(rd), .rvfi_rd_wdata(wdata),
    .trace_valid_o(t_valid), .trace_ready_i(ready), .trace_order_o(t_order),
    .trace_pc_o(t_pc), .trace_insn_o(t_insn), .trace_rd_addr_o(t_rd),
    .trace_rd_wdata_o(t_wdata), .trace_flags_o(t_flags), .level_o(level),
    .drop_cnt_o(drops), .frozen_o(frozen)
  );

  typedef struct packed {
    logic [31:0] order, pc, insn;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [2:0]  flags;
  } rec_t;

  typedef struct packed {
    logic [31:0] pc, insn;
    logic        intr;
    logic [2:0]  exp_flags;
    logic [4:0]  exp_level;
  } vec_t;

  // Reference model: record queue, drop count, lost marker, mode 0=idle 1=run 2=frozen.
  rec_t mq[$];
  int   m_drops = 0;
  bit   m_lost = 1'b0;
  int   m_mode = 0;
  int   total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_drops = 0;
    m_lost  = 1'b0;
    m_mode  = 0;
  endtask

  task automatic model_step();
    rec_t r;
    if (clear) begin
      model_reset();
      return;
    end
    if (mq.size() != 0 && ready) void'(mq.pop_front());
    if (m_mode == 1 && valid) begin
      if (mq.size() < DEPTH) begin
        r.order = order[31:0]; r.pc = pc; r.insn = insn; r.rd = rd; r.wd = wdata;
        r.flags = {m_lost, intr, trap};
        mq.push_back(r);
        m_lost = 1'b0;
      end else begin
        if (m_drops < DMAX) m_drops++;
        m_lost = 1'b1;
      end
    end
    if (FREEZE && m_mode == 1 && valid && trap) m_mode = 2;
    else if (m_mode == 0 && en) m_mode = 1;
    else if (m_mode == 1 && !en) m_mode = 0;
  endtask

  task automatic check_all();
    chk("valid", t_valid, mq.size() != 0);
    chk("level", level, mq.size());
    chk("drop_cnt", drops, m_drops);
    chk("frozen", frozen, m_mode == 2);
    if (mq.size() != 0) begin
      chk("pc", t_pc, mq[0].pc);
      chk("insn", t_insn, mq[0].insn);
      chk("order", t_order, mq[0].order);
      chk("rd", {t_rd, t_wdata}, {mq[0].rd, mq[0].wd});
      chk("flags", t_flags, mq[0].flags);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_rv(input logic [31:0] p, input logic [31:0] i, input bit tr, input bit it);
    valid = 1'b1; pc = p; insn = i; trap = tr; intr = it;
    rd = 5'($urandom); wdata = $urandom;
    order = order + 64'd1;
  endtask

  task automatic retire(input logic [31:0] p, input bit tr);
    set_rv(p, $urandom, tr, 1'b0);
    step();
    valid = 1'b0; trap = 1'b0;
  endtask

  task automatic do_clear();
    valid = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{32'h80,  32'h00000013, 1'b0, 3'b000, 5'd1};
    tbl[1] = '{32'h84,  32'h00100093, 1'b0, 3'b000, 5'd1};
    tbl[2] = '{32'h88,  32'h00208113, 1'b0, 3'b000, 5'd1};
    tbl[3] = '{32'h200, 32'h34202573, 1'b1, 3'b010, 5'd1};
    tbl[4] = '{32'h204, 32'h00a00023, 1'b0, 3'b000, 5'd1};
    tbl[5] = '{32'h208, 32'h30200073, 1'b1, 3'b010, 5'd1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", t_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_drops", drops, 0);
    chk("rst_payload", {t_pc, t_insn, t_flags}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: back-to-back retirements drained immediately
    en = 1'b1; ready = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      set_rv(tbl[k].pc, tbl[k].insn, 1'b0, tbl[k].intr);
      step();
      chk("tbl_pc", t_pc, tbl[k].pc);
      chk("tbl_insn", t_insn, tbl[k].insn);
      chk("tbl_flags", t_flags, tbl[k].exp_flags);
      chk("tbl_level", level, tbl[k].exp_level);
    end
    valid = 1'b0; intr = 1'b0;
    step();
    chk("tbl_empty", level, 0);

    // Overflow: 18 retirements into 16 slots, then lost flag on next record
    do_clear();
    ready = 1'b0;
    for (int k = 0; k < 18; k++) retire(32'h1000 + 32'(4 * k), 1'b0);
    chk("ovf_level", level, 16);
    chk("ovf_drops", drops, 2);
    ready = 1'b1;
    retire(32'h2000, 1'b0);
    for (int j = 0; j < 16; j++) begin
      chk("ovf_pc", t_pc, (j < 15) ? 32'h1000 + 32'(4 * (j + 1)) : 32'h2000);
      chk("ovf_flags", t_flags, (j < 15) ? 3'b000 : 3'b100);
      step();
    end
    chk("ovf_drained", level, 0);

    // Full with simultaneous push and pop
    do_clear();
    ready = 1'b0;
    for (int k = 0; k < 16; k++) retire(32'h3000 + 32'(4 * k), 1'b0);
    ready = 1'b1;
    retire(32'h3100, 1'b0);
    chk("full_pp_level", level, 16);
    chk("full_pp_drops", drops, 0);
    chk("full_pp_head", t_pc, 32'h3004);

    // Disabled capture, then clear during drain
    en = 1'b0; ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) retire(32'h4000 + 32'(4 * k), 1'b0);
    chk("idle_level", level, 16);
    chk("idle_drops", drops, 0);
    ready = 1'b1;
    repeat (3) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_valid", t_valid, 0);
    chk("clr_level", level, 0);
    en = 1'b1;
    step();
    set_rv(32'h4100, 32'h13, 1'b0, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0; valid = 1'b0;
    chk("clr_push_level", level, 0);
    step();

    // Trap handling
    ready = 1'b0;
    retire(32'h100, 1'b1);
    retire(32'h104, 1'b0);
    retire(32'h108, 1'b0);
    chk("trap_pc", t_pc, 32'h100);
    chk("trap_flags", t_flags, 3'b001);
`ifdef CVE2_TRACE_BUF_FREEZE_ON_TRAP_EN
    chk("trap_level", level, 1);
    chk("trap_frozen", frozen, 1);
    ready = 1'b1;
    step();
    chk("frz_drain", level, 0);
    chk("frz_hold", frozen, 1);
    do_clear();
    chk("frz_cleared", frozen, 0);
    retire(32'h200, 1'b0);
    chk("frz_resume", t_pc, 32'h200);
    do_clear();
    ready = 1'b0;
    for (int k = 0; k < 16; k++) retire(32'h5000 + 32'(4 * k), 1'b0);
    retire(32'h5100, 1'b1);
    chk("frz_drop_trap", frozen, 1);
    chk("frz_drop_cnt", drops, 1);
`else
    chk("trap_level", level, 3);
    chk("trap_frozen", frozen, 0);
`endif

    // Randomized traffic against the model
    do_clear();
    for (int blk = 0; blk < 10; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(10, 90);
      for (int c = 0; c < 50; c++) begin
        en    = ($urandom_range(0, 19) != 0);
        clear = ($urandom_range(0, 79) == 0);
        ready = ($urandom_range(0, 99) < rdy_pct);
        if ($urandom_range(0, 9) < 7) set_rv($urandom, $urandom, FREEZE ? 1'b0 : 1'($urandom), 1'($urandom));
        else valid = 1'b0;
        step();
      end
    end
    clear = 1'b0; en = 1'b1;

    // Drop counter saturation, then asynchronous reset mid-drain
    do_clear();
    ready = 1'b0;
    for (int k = 0; k < 36; k++) retire(32'h6000 + 32'(4 * k), 1'b0);
    chk("sat_drops", drops, DMAX);
    chk("sat_level", level, 16);
    ready = 1'b1;
    repeat (2) step();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", t_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_drops", drops, 0);
    chk("arst_payload", {t_pc, t_insn, t_order, t_flags, frozen}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
